// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: ARM condition codes,
// controller states and the legal range of the flush length.
package branch_resolve_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLUSH_STAGES_MIN = 1;
  localparam int FLUSH_STAGES_MAX = 7;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FLAGS = 2'd1,
    FLUSH      = 2'd2
  } state_e;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational ARM condition-code evaluator; nzcv is {N,Z,C,V}.
// Kept standalone so the execute stage can share it.
module cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       true
);

  logic w_n, w_z, w_c, w_v;

  assign {w_n, w_z, w_c, w_v} = nzcv;

  always_comb begin
    true = 1'b0;
    case (cond)
      COND_EQ: true = w_z;
      COND_NE: true = !w_z;
      COND_CS: true = w_c;
      COND_CC: true = !w_c;
      COND_MI: true = w_n;
      COND_PL: true = !w_n;
      COND_VS: true = w_v;
      COND_VC: true = !w_v;
      COND_HI: true = w_c && !w_z;
      COND_LS: true = !w_c || w_z;
      COND_GE: true = (w_n == w_v);
      COND_LT: true = (w_n != w_v);
      COND_GT: true = !w_z && (w_n == w_v);
      COND_LE: true = w_z || (w_n != w_v);
      COND_AL: true = 1'b1;
      default: true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates the branch condition (waiting for flags if
// needed), redirects fetch, writes the link register and flushes the pipe.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int AW           = 32,
  parameter int FLUSH_STAGES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             B,
  input  logic             BL,
  input  logic [3:0]       cond,
  input  logic [3:0]       nzcv,
  input  logic             flags_valid,
  input  logic             stall,
  input  logic [AW-1:0]    target,
  input  logic [AW-1:0]    pc_plus4,
  input  logic             clr_stats,
  output logic             T_address,
  output logic [AW-1:0]    target_pc,
  output logic             BL_reg,
  output logic [AW-1:0]    link_addr,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  // Out-of-range lengths are clamped into the legal window.
  localparam int FS_EFF = (FLUSH_STAGES < FLUSH_STAGES_MIN) ? FLUSH_STAGES_MIN :
                          (FLUSH_STAGES > FLUSH_STAGES_MAX) ? FLUSH_STAGES_MAX :
                          FLUSH_STAGES;
  localparam logic [2:0] FLUSH_LAST = 3'(FS_EFF - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [2:0]        r_flush_cnt;
  logic [3:0]        r_cap_cond;
  logic              r_cap_bl;
  logic [AW-1:0]     r_cap_target;
  logic [AW-1:0]     r_cap_pc4;
  logic              r_t_address;
  logic              r_bl_reg;
  logic [AW-1:0]     r_target_pc;
  logic [AW-1:0]     r_link_addr;
  logic [CNT_W-1:0]  r_br_count;
  logic [CNT_W-1:0]  r_taken_count;

  logic              w_in_wait;
  logic              w_accept;
  logic              w_resolve;
  logic              w_capture;
  logic              w_cond_true;
  logic              w_taken;
  logic [3:0]        w_cond;
  logic              w_bl;
  logic [AW-1:0]     w_target;
  logic [AW-1:0]     w_pc4;

  assign w_in_wait = (r_state == WAIT_FLAGS);
  assign w_accept  = (r_state == IDLE) && B && !stall;
  assign w_resolve = (w_accept || w_in_wait) && flags_valid;
  assign w_capture = w_accept && !flags_valid;

  // While waiting, the captured fields drive resolution; nzcv is always live.
  assign w_cond   = w_in_wait ? r_cap_cond   : cond;
  assign w_bl     = w_in_wait ? r_cap_bl     : BL;
  assign w_target = w_in_wait ? r_cap_target : target;
  assign w_pc4    = w_in_wait ? r_cap_pc4    : pc_plus4;

  cond_eval u_cond_eval (
    .cond (w_cond),
    .nzcv (nzcv),
    .true (w_cond_true)
  );

  assign w_taken = w_resolve && w_cond_true;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_taken)        w_state_nxt = FLUSH;
        else if (w_capture) w_state_nxt = WAIT_FLAGS;
      end
      WAIT_FLAGS: begin
        if (w_resolve) w_state_nxt = w_taken ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (r_flush_cnt == 3'd0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_cnt  <= '0;
      r_cap_cond   <= '0;
      r_cap_bl     <= 1'b0;
      r_cap_target <= '0;
      r_cap_pc4    <= '0;
      r_t_address  <= 1'b0;
      r_bl_reg     <= 1'b0;
      r_target_pc  <= '0;
      r_link_addr  <= '0;
    end else begin
      r_t_address <= w_taken;
      r_bl_reg    <= w_taken && w_bl;
      if (w_taken) r_target_pc <= w_target;
      if (w_taken && w_bl) r_link_addr <= w_pc4;
      if (w_capture) begin
        r_cap_cond   <= cond;
        r_cap_bl     <= BL;
        r_cap_target <= target;
        r_cap_pc4    <= pc_plus4;
      end
      // Down-counter reaches zero on the last flush cycle.
      if (w_taken)
        r_flush_cnt <= FLUSH_LAST;
      else if (r_state == FLUSH && r_flush_cnt != 3'd0)
        r_flush_cnt <= r_flush_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else begin
      if (w_resolve && r_br_count != '1)   r_br_count    <= r_br_count + 1'b1;
      if (w_taken && r_taken_count != '1)  r_taken_count <= r_taken_count + 1'b1;
    end
  end

  assign T_address   = r_t_address;
  assign target_pc   = r_target_pc;
  assign BL_reg      = r_bl_reg;
  assign link_addr   = r_link_addr;
  assign flush       = (r_state == FLUSH);
  assign busy        = (r_state != IDLE);
  assign br_count    = r_br_count;
  assign taken_count = r_taken_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: instance A uses default parameters, instance B uses
// FLUSH_STAGES=3 and CNT_W=2; both share the same stimulus.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset, B, BL, flags_valid, stall, clr_stats;
  logic [3:0]  cond, nzcv;
  logic [31:0] target, pc_plus4;

  logic        a_t, a_bl, a_flush, a_busy;
  logic [31:0] a_tpc, a_link;
  logic [15:0] a_br, a_tk;
  logic        b_t, b_bl, b_flush, b_busy;
  logic [31:0] b_tpc, b_link;
  logic [1:0]  b_br, b_tk;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.AW(32), .FLUSH_STAGES(2), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .B(B), .BL(BL), .cond(cond), .nzcv(nzcv),
    .flags_valid(flags_valid), .stall(stall), .target(target),
    .pc_plus4(pc_plus4), .clr_stats(clr_stats), .T_address(a_t),
    .target_pc(a_tpc), .BL_reg(a_bl), .link_addr(a_link), .flush(a_flush),
    .busy(a_busy), .br_count(a_br), .taken_count(a_tk)
  );

  branch_resolve_unit #(.AW(32), .FLUSH_STAGES(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .B(B), .BL(BL), .cond(cond), .nzcv(nzcv),
    .flags_valid(flags_valid), .stall(stall), .target(target),
    .pc_plus4(pc_plus4), .clr_stats(clr_stats), .T_address(b_t),
    .target_pc(b_tpc), .BL_reg(b_bl), .link_addr(b_link), .flush(b_flush),
    .busy(b_busy), .br_count(b_br), .taken_count(b_tk)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cond, nzcv, expected taken
  logic [8:0] cc_tab [14] = '{
    {4'h8, 4'b0010, 1'b1}, {4'h8, 4'b0110, 1'b0}, {4'h9, 4'b0110, 1'b1},
    {4'hA, 4'b1001, 1'b1}, {4'hC, 4'b0000, 1'b1}, {4'hC, 4'b0100, 1'b0},
    {4'hD, 4'b1000, 1'b1}, {4'h4, 4'b1000, 1'b1}, {4'h5, 4'b1000, 1'b0},
    {4'h6, 4'b0001, 1'b1}, {4'h7, 4'b0001, 1'b0}, {4'h2, 4'b0010, 1'b1},
    {4'h3, 4'b0010, 1'b0}, {4'hF, 4'b1111, 1'b0}
  };

  initial begin
    logic [8:0] ent;
    reset = 1'b1; B = 1'b0; BL = 1'b0; flags_valid = 1'b0; stall = 1'b0;
    clr_stats = 1'b0; cond = 4'h0; nzcv = 4'h0; target = '0; pc_plus4 = '0;
    tick(); tick();
    check("rst_t", {31'd0, a_t}, 32'd0);
    check("rst_flush", {31'd0, a_flush}, 32'd0);
    check("rst_busy", {31'd0, b_busy}, 32'd0);
    check("rst_tpc", a_tpc, 32'd0);
    check("rst_br", {16'd0, a_br}, 32'd0);
    reset = 1'b0;

    // EQ taken with link
    cond = 4'h0; nzcv = 4'b0100; flags_valid = 1'b1; B = 1'b1; BL = 1'b1;
    target = 32'h100; pc_plus4 = 32'h24;
    tick();
    B = 1'b0; BL = 1'b0;
    check("eq_t", {31'd0, a_t}, 32'd1);
    check("eq_tpc", a_tpc, 32'h100);
    check("eq_bl", {31'd0, a_bl}, 32'd1);
    check("eq_link", a_link, 32'h24);
    check("eq_flush1", {31'd0, a_flush}, 32'd1);
    check("eq_br", {16'd0, a_br}, 32'd1);
    check("eq_tk", {16'd0, a_tk}, 32'd1);
    tick();
    check("eq_t_off", {31'd0, a_t}, 32'd0);
    check("eq_bl_off", {31'd0, a_bl}, 32'd0);
    check("eq_flush2", {31'd0, a_flush}, 32'd1);
    check("eq_tpc_hold", a_tpc, 32'h100);
    tick();
    check("eq_flush_end_a", {31'd0, a_flush}, 32'd0);
    check("eq_busy_end_a", {31'd0, a_busy}, 32'd0);
    check("eq_flush3_b", {31'd0, b_flush}, 32'd1);
    tick();
    check("eq_flush_end_b", {31'd0, b_flush}, 32'd0);

    // NE not taken
    cond = 4'h1; nzcv = 4'b0100; B = 1'b1;
    tick();
    B = 1'b0;
    check("ne_t", {31'd0, a_t}, 32'd0);
    check("ne_flush", {31'd0, a_flush}, 32'd0);
    check("ne_busy", {31'd0, a_busy}, 32'd0);
    check("ne_br", {16'd0, a_br}, 32'd2);
    check("ne_tk", {16'd0, a_tk}, 32'd1);

    // Flags late: LT captured, later inputs must be ignored
    cond = 4'hB; nzcv = 4'b0000; flags_valid = 1'b0; B = 1'b1;
    target = 32'h200; pc_plus4 = 32'h44;
    tick();
    check("wt_busy1", {31'd0, a_busy}, 32'd1);
    cond = 4'h0; target = 32'h999; BL = 1'b1;
    tick();
    check("wt_busy2", {31'd0, a_busy}, 32'd1);
    tick();
    check("wt_busy3", {31'd0, a_busy}, 32'd1);
    check("wt_t", {31'd0, a_t}, 32'd0);
    flags_valid = 1'b1; nzcv = 4'b1000;
    tick();
    B = 1'b0; BL = 1'b0;
    check("wt_t_pulse", {31'd0, a_t}, 32'd1);
    check("wt_tpc", a_tpc, 32'h200);
    check("wt_bl", {31'd0, a_bl}, 32'd0);
    check("wt_link_hold", a_link, 32'h24);
    check("wt_br", {16'd0, a_br}, 32'd3);
    check("wt_tk", {16'd0, a_tk}, 32'd2);
    tick(); tick(); tick();
    check("wt_idle_b", {31'd0, b_busy}, 32'd0);

    // Back-to-back AL branches with B held high, stall during flush
    cond = 4'hE; B = 1'b1; target = 32'h300;
    tick();
    check("bb_t_a1", {31'd0, a_t}, 32'd1);
    check("bb_t_b1", {31'd0, b_t}, 32'd1);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    check("bb_t_a2", {31'd0, a_t}, 32'd0);
    check("bb_fl_a2", {31'd0, a_flush}, 32'd1);
    tick();
    check("bb_fl_a3", {31'd0, a_flush}, 32'd0);
    check("bb_fl_b3", {31'd0, b_flush}, 32'd1);
    check("bb_t_b3", {31'd0, b_t}, 32'd0);
    tick();
    check("bb_t_a4", {31'd0, a_t}, 32'd1);
    check("bb_fl_a4", {31'd0, a_flush}, 32'd1);
    check("bb_t_b4", {31'd0, b_t}, 32'd0);
    check("bb_fl_b4", {31'd0, b_flush}, 32'd0);
    tick();
    B = 1'b0;
    check("bb_t_b5", {31'd0, b_t}, 32'd1);
    check("bb_br_a", {16'd0, a_br}, 32'd5);
    check("bb_tk_a", {16'd0, a_tk}, 32'd4);
    check("sat_br_b", {30'd0, b_br}, 32'd3);
    check("sat_tk_b", {30'd0, b_tk}, 32'd3);
    tick(); tick(); tick();

    // Clear wins over a simultaneous increment
    B = 1'b1; clr_stats = 1'b1;
    tick();
    B = 1'b0; clr_stats = 1'b0;
    check("clr_t", {31'd0, b_t}, 32'd1);
    check("clr_br_a", {16'd0, a_br}, 32'd0);
    check("clr_tk_b", {30'd0, b_tk}, 32'd0);
    tick(); tick(); tick();

    // Condition table sweep
    for (int i = 0; i < 14; i++) begin
      ent = cc_tab[i];
      cond = ent[8:5]; nzcv = ent[4:1]; B = 1'b1;
      tick();
      B = 1'b0;
      check($sformatf("cc_%0h_%0h", ent[8:5], ent[4:1]), {31'd0, a_t}, {31'd0, ent[0]});
      tick(); tick(); tick();
    end

    // Reset during second flush cycle
    cond = 4'hE; B = 1'b1; BL = 1'b1; target = 32'h400; pc_plus4 = 32'h80;
    tick();
    B = 1'b0; BL = 1'b0;
    check("rf_link", a_link, 32'h80);
    check("rf_bl", {31'd0, a_bl}, 32'd1);
    tick();
    check("rf_flush2", {31'd0, a_flush}, 32'd1);
    reset = 1'b1;
    tick();
    check("rf_flush", {31'd0, a_flush}, 32'd0);
    check("rf_busy", {31'd0, b_busy}, 32'd0);
    check("rf_t", {31'd0, a_t}, 32'd0);
    check("rf_tpc", a_tpc, 32'd0);
    check("rf_link0", b_link, 32'd0);
    check("rf_br", {16'd0, a_br}, 32'd0);
    reset = 1'b0;
    tick();
    check("rf_t_after", {31'd0, a_t}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter AW, default 32, address width of the target, PC and link paths.
REQ-002 Parameter FLUSH_STAGES, default 2, legal 1..7, number of cycles flush is held after a taken branch.
REQ-003 Parameter CNT_W, default 16, width of the statistics counters.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 B  input  1  branch instruction present, from the control unit.
REQ-007 BL  input  1  branch-with-link.
REQ-008 cond  input  4  ARM condition field.
REQ-009 nzcv  input  4  flags {N,Z,C,V}.
REQ-010 flags_valid  input  1  nzcv reflects all older flag-setting instructions.
REQ-011 stall  input  1  pipeline stall; B is not sampled while high.
REQ-012 target  input  AW  branch target address.
REQ-013 pc_plus4  input  AW  return address for BL.
REQ-014 clr_stats  input  1  synchronous clear of the statistics counters.
REQ-015 T_address  output  1  one-cycle pulse: fetch redirects to target_pc.
REQ-016 target_pc  output  AW  redirect address, valid with T_address.
REQ-017 BL_reg  output  1  one-cycle pulse: write link_addr to R14.
REQ-018 link_addr  output  AW  link value, valid with BL_reg.
REQ-019 flush  output  1  squash younger pipeline stages.
REQ-020 busy  output  1  high in WAIT_FLAGS and FLUSH.
REQ-021 br_count  output  CNT_W  number of resolved branches.
REQ-022 taken_count  output  CNT_W  number of taken branches.

Function
REQ-023 Condition evaluation SHALL follow the ARM table for codes 0000-1110: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; code 1111 evaluates false.
REQ-024 The state machine SHALL have three states: IDLE, WAIT_FLAGS and FLUSH.
REQ-025 In IDLE with B=1, stall=0 and flags_valid=1, the block SHALL resolve in the same cycle using the current nzcv.
REQ-026 In IDLE with B=1, stall=0 and flags_valid=0, the block SHALL capture cond, BL, target and pc_plus4, then enter WAIT_FLAGS.
REQ-027 In WAIT_FLAGS the block SHALL ignore B and stall, and SHALL resolve against the live nzcv, using the captured fields, in the first cycle flags_valid=1.
REQ-028 On a taken resolution at edge t, the block SHALL, in the cycle following edge t:
- pulse T_address for exactly one cycle;
- drive target_pc with the resolved target;
- pulse BL_reg if BL was set, with link_addr driven with the resolved pc_plus4;
- enter FLUSH.
REQ-029 On a not-taken resolution, the next state SHALL be IDLE, with no T_address, BL_reg or flush.
REQ-030 flush SHALL be high for exactly FLUSH_STAGES consecutive cycles, starting in the same cycle as T_address; the state SHALL then return to IDLE.
REQ-031 B SHALL be ignored during FLUSH (squashed instructions), and stall SHALL NOT extend FLUSH.
REQ-032 A B arriving in the first IDLE cycle after FLUSH SHALL be accepted normally, giving back-to-back branches with no dead cycle.
REQ-033 target_pc and link_addr SHALL hold their last values when not pulsed.
REQ-034 br_count SHALL increment on every resolution and taken_count on every taken resolution; both SHALL saturate at all-ones.
REQ-035 clr_stats SHALL zero both counters and SHALL take priority over a simultaneous increment.

Reset
REQ-036 Reset SHALL force the state to IDLE and zero every output and captured register, taking priority over all other inputs.
REQ-037 Reset asserted mid-WAIT_FLAGS or mid-FLUSH SHALL abort the operation with no pulse on the following cycle.

Structure
REQ-038 A shared package SHALL hold the condition-code constants (EQ..AL, NV), the state enum, and the FLUSH_STAGES legal bounds.
REQ-039 Condition evaluation SHALL be the combinational sub-module cond_eval (inputs cond and nzcv, output true), reusable by the execute stage.

Verification
REQ-040 cond=0000 (EQ), nzcv=0100, flags_valid=1, B=1, BL=1, target=0x100, pc_plus4=0x24 -> next cycle T_address=1, target_pc=0x100, BL_reg=1, link_addr=0x24; flush high 2 cycles; br_count=1, taken_count=1.
REQ-041 cond=0001 (NE), nzcv=0100, B=1 -> no pulse, no flush, state IDLE; br_count=1, taken_count=0.
REQ-042 B=1 with flags_valid=0 for 3 cycles, then flags_valid=1 with nzcv=1000 and captured cond=1011 (LT) -> busy for 3 cycles, then a taken pulse; a B asserted during the wait is ignored.
REQ-043 Taken branch with FLUSH_STAGES=3, B held high throughout -> flush high 3 cycles, B ignored during flush, next branch resolved in the first cycle after flush.
REQ-044 CNT_W=2, five taken branches -> counters saturate at 3; clr_stats asserted together with a resolution -> counters read 0.
REQ-045 Reset asserted during the second FLUSH cycle -> flush=0, busy=0, all outputs 0 in the next cycle.
